// File: rtl/memory_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_arbiter_pkg
// Description : Shared types and constants for the main-memory access arbiter.
//               It holds the memory process latencies, the requester id and
//               serial types, and the read-route FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_access_arbiter_pkg;

  // Busy cycles the memory needs after accepting each kind of access.
  localparam int MEMORY_READ_PROCESS_LATENCY  = 2;
  localparam int MEMORY_WRITE_PROCESS_LATENCY = 2;

  localparam int MEM_ARB_NUM_REQ      = 2;
  localparam int MEM_ARB_SERIAL_WIDTH = 8;
  localparam int MEM_ARB_ID_WIDTH     = (MEM_ARB_NUM_REQ > 1) ? $clog2(MEM_ARB_NUM_REQ) : 1;

  typedef logic [MEM_ARB_ID_WIDTH-1:0]     MemArbReqIdPath;
  typedef logic [MEM_ARB_SERIAL_WIDTH-1:0] MemArbSerialPath;

  // One outstanding read: the requester the data belongs to and its serial.
  typedef struct packed {
    MemArbReqIdPath  id;
    MemArbSerialPath serial;
  } MemArbRouteEntry;

  // The busy counter only has to hold latencies in the range 1..3.
  typedef logic [1:0] MemoryProcessLatencyCount;

endpackage
`default_nettype wire

// File: rtl/mem_arb_route_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_route_queue
// Description : Synchronous FIFO of read-route entries. DEPTH need not be a
//               power of two; both pointers wrap explicitly at DEPTH-1.
// Ports       : clk, rstN      - clock, asynchronous active-low reset
//               push, push_entry - write an entry (ignored when full)
//               pop            - drop the head entry (ignored when empty)
//               full, empty    - occupancy flags
//               count          - number of entries held
//               head           - oldest entry (valid when not empty)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_route_queue
  import memory_access_arbiter_pkg::*;
#(
  parameter int DEPTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  MemArbRouteEntry  push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output MemArbRouteEntry  head
);

  MemArbRouteEntry  storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_arbiter
// Description : Shares the main-memory port between NUM_REQ requesters with
//               round-robin arbitration, enforces memory occupancy after each
//               access, hands out read/write serials and routes in-order read
//               returns back to the requester that issued each read.
// Ports       : clk, rstN                 - clock, asynchronous active-low reset
//               reqValid/IsWrite/Addr/WriteData - per-requester request
//               reqReady, reqSerial        - one-hot accept and its serial
//               memIsRead/IsWrite/Addr/WriteData - registered memory command
//               memReadValid, memReadData  - in-order read return
//               respValid/Data/Serial      - registered routed read response
//               routeError                 - sticky: return with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_arbiter
  import memory_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = MEM_ARB_NUM_REQ,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int SERIAL_WIDTH    = MEM_ARB_SERIAL_WIDTH,
  parameter int READ_LATENCY    = MEMORY_READ_PROCESS_LATENCY,
  parameter int WRITE_LATENCY   = MEMORY_WRITE_PROCESS_LATENCY,
  parameter int MAX_OUTSTANDING = 5
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ-1:0]            reqIsWrite,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWriteData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [SERIAL_WIDTH-1:0]       reqSerial,
  output logic                          memIsRead,
  output logic                          memIsWrite,
  output logic [ADDR_WIDTH-1:0]         memAddr,
  output logic [DATA_WIDTH-1:0]         memWriteData,
  input  logic                          memReadValid,
  input  logic [DATA_WIDTH-1:0]         memReadData,
  output logic [NUM_REQ-1:0]            respValid,
  output logic [DATA_WIDTH-1:0]         respData,
  output logic [SERIAL_WIDTH-1:0]       respSerial,
  output logic                          routeError
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  MemArbReqIdPath           rr_ptr;
  MemoryProcessLatencyCount busy;
  logic [SERIAL_WIDTH-1:0]  read_serial;
  logic [SERIAL_WIDTH-1:0]  write_serial;

  logic                     accept;
  logic                     accept_is_write;
  MemArbReqIdPath           winner;
  logic [ADDR_WIDTH-1:0]    win_addr;
  logic [DATA_WIDTH-1:0]    win_wdata;
  int                       idx;

  logic                     q_push;
  logic                     q_pop;
  logic                     q_full;
  logic                     q_empty;
  logic [CNT_W-1:0]         q_count;
  MemArbRouteEntry          q_entry;
  MemArbRouteEntry          q_head;

  // Round-robin search starting at rr_ptr. Read eligibility looks at the
  // current FIFO count only, so a pop this cycle never frees a slot for a
  // read in the same cycle. Nothing is granted while reset is asserted.
  always_comb begin
    accept          = 1'b0;
    accept_is_write = 1'b0;
    winner          = '0;
    idx             = 0;
    if (rstN && busy == '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (!accept && reqValid[idx] &&
            (reqIsWrite[idx] || q_count < CNT_W'(MAX_OUTSTANDING))) begin
          accept          = 1'b1;
          accept_is_write = reqIsWrite[idx];
          winner          = MemArbReqIdPath'(idx);
        end
      end
    end
  end

  always_comb begin
    reqReady = '0;
    if (accept) reqReady[winner] = 1'b1;
  end

  assign reqSerial = !accept        ? '0 :
                     accept_is_write ? write_serial : read_serial;

  assign win_addr  = reqAddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = reqWriteData[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

  assign q_push         = accept && !accept_is_write && !q_full;
  assign q_pop          = memReadValid && !q_empty;
  assign q_entry.id     = winner;
  assign q_entry.serial = MemArbSerialPath'(read_serial);

  mem_arb_route_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_queue (
    .clk        (clk),
    .rstN       (rstN),
    .push       (q_push),
    .push_entry (q_entry),
    .pop        (q_pop),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count),
    .head       (q_head)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr       <= '0;
      busy         <= '0;
      read_serial  <= '0;
      write_serial <= '0;
      memIsRead    <= 1'b0;
      memIsWrite   <= 1'b0;
      memAddr      <= '0;
      memWriteData <= '0;
      respValid    <= '0;
      respData     <= '0;
      respSerial   <= '0;
      routeError   <= 1'b0;
    end else begin
      memIsRead    <= accept && !accept_is_write;
      memIsWrite   <= accept && accept_is_write;
      memAddr      <= accept ? win_addr : '0;
      memWriteData <= (accept && accept_is_write) ? win_wdata : '0;

      // busy holds the number of blocked cycles still to come after the
      // accept cycle, so the next accept lands exactly LATENCY cycles later.
      if (accept) begin
        busy <= accept_is_write ? MemoryProcessLatencyCount'(WRITE_LATENCY - 1)
                                : MemoryProcessLatencyCount'(READ_LATENCY - 1);
        rr_ptr <= MemArbReqIdPath'((int'(winner) + 1) % NUM_REQ);
        if (accept_is_write) write_serial <= write_serial + SERIAL_WIDTH'(1);
        else                 read_serial  <= read_serial + SERIAL_WIDTH'(1);
      end else if (busy != '0) begin
        busy <= busy - MemoryProcessLatencyCount'(1);
      end

      respValid  <= '0;
      respData   <= '0;
      respSerial <= '0;
      if (q_pop) begin
        respValid[q_head.id] <= 1'b1;
        respData             <= memReadData;
        respSerial           <= SERIAL_WIDTH'(q_head.serial);
      end

      if (memReadValid && q_empty) routeError <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_arbiter
// Description : Self-checking bench for memory_access_arbiter. A behavioural
//               model predicts every output each cycle; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_arbiter;

  localparam int NR   = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = 8;
  localparam int RL   = 2;
  localparam int WL   = 2;
  localparam int MAXO = 5;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NR-1:0]     reqValid, reqIsWrite, reqReady, respValid;
  logic [NR*AW-1:0]  reqAddr;
  logic [NR*DW-1:0]  reqWriteData;
  logic [SW-1:0]     reqSerial, respSerial;
  logic              memIsRead, memIsWrite, memReadValid, routeError;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memWriteData, memReadData, respData;

  memory_access_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqIsWrite(reqIsWrite), .reqAddr(reqAddr),
    .reqWriteData(reqWriteData), .reqReady(reqReady), .reqSerial(reqSerial),
    .memIsRead(memIsRead), .memIsWrite(memIsWrite), .memAddr(memAddr),
    .memWriteData(memWriteData), .memReadValid(memReadValid),
    .memReadData(memReadData), .respValid(respValid), .respData(respData),
    .respSerial(respSerial), .routeError(routeError)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int id; int serial; } route_t;
  route_t        rq[$];
  int            cyc = 0, free_at = 0, rr = 0, rd_ser = 0, wr_ser = 0;
  bit            err = 0;
  logic          e_rd = 0, e_wr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [NR-1:0] e_rv = '0;
  logic [SW-1:0] e_rser = '0;

  always @(negedge clk) begin : model
    int            win;
    int            i;
    logic [NR-1:0] e_grant;
    logic [SW-1:0] e_ser;
    route_t        h;
    if (!rstN) begin
      chk("rst_ready", reqReady, 0);
      chk("rst_serial", reqSerial, 0);
      chk("rst_cmd", {memIsRead, memIsWrite, memAddr, memWriteData}, 0);
      chk("rst_resp", {respValid, respData, respSerial, routeError}, 0);
      rq.delete();
      free_at = cyc; rr = 0; rd_ser = 0; wr_ser = 0; err = 0;
      e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      e_rv = '0; e_rdata = '0; e_rser = '0;
    end else begin
      win = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < NR; k++) begin
          i = (rr + k) % NR;
          if (win < 0 && reqValid[i] && (reqIsWrite[i] || rq.size() < MAXO)) win = i;
        end
      end
      e_grant = (win >= 0) ? NR'(1 << win) : '0;
      e_ser   = (win < 0) ? '0 : (reqIsWrite[win] ? SW'(wr_ser) : SW'(rd_ser));
      chk("m_ready", reqReady, e_grant);
      chk("m_serial", reqSerial, e_ser);
      chk("m_cmd", {memIsRead, memIsWrite, memAddr, memWriteData}, {e_rd, e_wr, e_addr, e_wdata});
      chk("m_resp", {respValid, respData, respSerial}, {e_rv, e_rdata, e_rser});
      chk("m_rterr", routeError, err);
      // advance model by one clock
      e_rv = '0; e_rdata = '0; e_rser = '0;
      if (memReadValid) begin
        if (rq.size() == 0) err = 1;
        else begin
          h = rq.pop_front();
          e_rv = NR'(1 << h.id); e_rdata = memReadData; e_rser = SW'(h.serial);
        end
      end
      e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      if (win >= 0) begin
        e_addr = reqAddr[win*AW +: AW];
        if (reqIsWrite[win]) begin
          e_wr = 1; e_wdata = reqWriteData[win*DW +: DW];
          wr_ser = (wr_ser + 1) % 256; free_at = cyc + WL;
        end else begin
          e_rd = 1; rq.push_back('{win, rd_ser});
          rd_ser = (rd_ser + 1) % 256; free_at = cyc + RL;
        end
        rr = (win + 1) % NR;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input string name, input logic [NR-1:0] exp);
    int lim = 0;
    #1;
    while (reqReady == '0 && lim < 20) begin
      @(posedge clk); #2; lim++;
    end
    chk(name, reqReady, exp);
  endtask

  logic [NR-1:0] ev_t2 [3];
  int            g, lim;

  initial begin
    reqValid = '0; reqIsWrite = '0; reqAddr = '0; reqWriteData = '0;
    memReadValid = 1'b0; memReadData = '0;
    ev_t2[0] = 2'b10; ev_t2[1] = 2'b01; ev_t2[2] = 2'b10;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // Single read from req0
    reqValid = 2'b01; reqIsWrite = 2'b00; reqAddr[31:0] = 32'h100;
    #1 chk("t1_grant", reqReady, 2'b01); chk("t1_serial", reqSerial, 0);
    tick(); reqValid = '0;
    chk("t1_memrd", memIsRead, 1); chk("t1_addr", memAddr, 32'h100);
    tick(); memReadValid = 1'b1; memReadData = 64'hDEADBEEF;
    tick(); memReadValid = 1'b0;
    chk("t1_rv", respValid, 2'b01); chk("t1_rdata", respData, 64'hDEADBEEF);
    chk("t1_rser", respSerial, 0);

    // Both hold reads: grants alternate every 2 cycles (pointer now at 1)
    tick(); tick();
    reqValid = 2'b11; reqIsWrite = 2'b00;
    reqAddr[31:0] = 32'h200; reqAddr[63:32] = 32'h300;
    #1 chk("t2_first", reqReady, 2'b10); chk("t2_ser", reqSerial, 1);
    repeat (5) tick();
    reqValid = '0;
    for (int k = 0; k < 3; k++) begin
      memReadValid = 1'b1; memReadData = 64'hA0 + 64'(k);
      tick();
      #1 chk("t2_rv", respValid, ev_t2[k]); chk("t2_rser", respSerial, 1 + k);
    end
    memReadValid = 1'b0;

    // Write from req1 then read from req0
    tick(); tick();
    reqValid = 2'b10; reqIsWrite = 2'b10;
    reqAddr[63:32] = 32'h400; reqWriteData[127:64] = 64'h12345678_9ABCDEF0;
    #1 chk("t3_wgrant", reqReady, 2'b10); chk("t3_wser", reqSerial, 0);
    tick(); reqValid = 2'b01; reqIsWrite = 2'b00; reqAddr[31:0] = 32'h500;
    #1 chk("t3_nogrant", reqReady, 2'b00); chk("t3_memwr", memIsWrite, 1);
    chk("t3_wdata", memWriteData, 64'h12345678_9ABCDEF0);
    tick();
    #1 chk("t3_rgrant", reqReady, 2'b01); chk("t3_rser", reqSerial, 4);
    tick(); reqValid = '0; memReadValid = 1'b1;
    tick(); memReadValid = 1'b0;
    #1 chk("t3_rv", respValid, 2'b01); chk("t3_rsern", respSerial, 4);

    // Fill five outstanding reads, then a write still wins
    tick(); tick();
    reqValid = 2'b01; reqIsWrite = 2'b00; reqAddr[31:0] = 32'h600;
    g = 0; lim = 0;
    while (g < 5 && lim < 40) begin
      #1; if (reqReady[0]) g++;
      tick(); lim++;
    end
    chk("t4_fills", g, 5);
    reqValid = 2'b11; reqIsWrite = 2'b10; reqWriteData[127:64] = 64'h55;
    wait_grant("t4_wr1", 2'b10);
    tick();
    wait_grant("t4_wr2", 2'b10);
    tick(); reqValid = 2'b01; reqIsWrite = 2'b00;
    repeat (3) tick();
    #1 chk("t4_blocked", reqReady, 2'b00);
    memReadValid = 1'b1;
    #1 chk("t4_popsame", reqReady, 2'b00);
    tick(); memReadValid = 1'b0;
    #1 chk("t4_afterpop", reqReady, 2'b01);
    tick(); reqValid = '0;

    // Drain five, then one extra return with the FIFO empty
    memReadValid = 1'b1;
    repeat (5) tick();
    tick(); memReadValid = 1'b0;
    #1 chk("t6_rterr", routeError, 1); chk("t6_norv", respValid, 2'b00);

    // Reset mid-burst clears everything immediately
    tick();
    reqValid = 2'b11; reqIsWrite = 2'b01;
    repeat (3) tick();
    memReadValid = 1'b1;
    tick();
    rstN = 1'b0; memReadValid = 1'b0;
    #1 chk("t7_ready", reqReady, 0); chk("t7_cmd", {memIsRead, memIsWrite}, 0);
    chk("t7_rv", respValid, 0); chk("t7_rterr", routeError, 0);
    tick();
    rstN = 1'b1; reqValid = 2'b01; reqIsWrite = 2'b00; reqAddr[31:0] = 32'h700;
    #1 chk("t7_grant", reqReady, 2'b01); chk("t7_ser", reqSerial, 0);
    tick(); reqValid = '0;
    chk("t7_memrd", memIsRead, 1); memReadValid = 1'b1; memReadData = 64'h77;
    tick(); memReadValid = 1'b0;
    #1 chk("t7_resp", respValid, 2'b01); chk("t7_rser", respSerial, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
